// File: rtl/ps2_host_tx_if.sv
// Command-side handshake and status bundle of the PS/2 host transmitter.
// The slave modport is the transmitter; the master is the command source.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_err, timeout
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_err, timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, frame shift-out
// on device clock falls, ack check, with a watchdog over the device phase.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned RTS_CYCLES     = 500,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    localparam int unsigned MAX_A   = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic          data_oe_q, data_oe_d;
    logic          ack_bit_q, ack_bit_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic          timeout_q, timeout_d;

    logic clk_s1_q, clk_s2_q, clk_h_q;
    logic dat_s1_q, dat_s2_q;
    logic fall_q;
    logic wd_active;

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_h_q   <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            fall_q    <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_oe_q <= 1'b0;
            ack_bit_q <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            clk_s1_q  <= ps2_clk_in;
            clk_s2_q  <= clk_s1_q;
            clk_h_q   <= clk_s2_q;
            dat_s1_q  <= ps2_data_in;
            dat_s2_q  <= dat_s1_q;
            fall_q    <= clk_h_q & ~clk_s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_oe_q <= data_oe_d;
            ack_bit_q <= ack_bit_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign wd_active = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_oe_d = data_oe_q;
        ack_bit_d = ack_bit_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (tx.tx_valid) begin
                    shift_d   = {~^tx.tx_data, tx.tx_data};
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_RTS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RTS: begin
                if (cnt_q == RTS_LAST) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_SEND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SEND: begin
                cnt_d = cnt_q + CW'(1);
                // Ones shift in behind the frame, so the tenth fall drives the stop bit (released).
                if (fall_q) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                cnt_d = cnt_q + CW'(1);
                if (fall_q) begin
                    ack_bit_d = dat_s2_q;
                    state_d   = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = cnt_q + CW'(1);
                // Linger one cycle after done so tx_ready rises the cycle after the pulse.
                if (done_q) begin
                    state_d = S_IDLE;
                end else if (clk_s2_q && dat_s2_q) begin
                    done_d    = 1'b1;
                    ack_err_d = ack_bit_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wd_active && (cnt_q == TO_LAST) && !done_q && !done_d) begin
            timeout_d = 1'b1;
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
        end
    end

    assign tx.tx_ready = (state_q == S_IDLE);
    assign tx.busy     = (state_q != S_IDLE);
    assign tx.done     = done_q;
    assign tx.ack_err  = ack_err_q;
    assign tx.timeout  = timeout_q;
    assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_RTS);
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a device model clocking at 40
// cycles, frame and completion scoreboards, and directed corner sequences.
module tb_ps2_host_tx;

    localparam int unsigned TO_CYC = 5000;
    localparam logic [1:0]  EV_DONE = 2'd1;
    localparam logic [1:0]  EV_TO   = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic       ack;
    } evt_t;

    typedef struct {
        logic [7:0]  data;
        bit          ack_low;
        logic [10:0] frame;
        logic        ack_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low, dev_data_low;
    wire  ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    wire  ps2_data_in = ~(ps2_data_oe | dev_data_low);

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;

    evt_t        exp_evt[$];
    logic [10:0] exp_frames[$];

    ps2_host_tx_if tx_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .RTS_CYCLES    (5),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx         (tx_if),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Bus monitor: completion scoreboard, clk-release timing and OE window tracking.
    int unsigned rel_cyc = 0, run = 0, last_win = 0, doe_off = 0, n_inhibit = 0;
    logic        prev_clk_oe = 1'b0, seen_doe = 1'b0, ready_next = 1'b0;
    evt_t        mon_e;

    always @(negedge clk) begin
        if (ready_next) begin
            check("ready_after_done", 32'(tx_if.tx_ready), 32'd1);
            ready_next = 1'b0;
        end
        if (tx_if.done || tx_if.timeout) begin
            if (exp_evt.size() == 0) begin
                check("unexpected_event", {30'd0, tx_if.done, tx_if.timeout}, 32'd0);
            end else begin
                mon_e = exp_evt.pop_front();
                check("event_done", 32'(tx_if.done), 32'(mon_e.kind == EV_DONE));
                check("event_timeout", 32'(tx_if.timeout), 32'(mon_e.kind == EV_TO));
                if (tx_if.done) begin
                    check("ack_err", 32'(tx_if.ack_err), 32'(mon_e.ack));
                    check("ready_low_at_done", 32'(tx_if.tx_ready), 32'd0);
                    ready_next = 1'b1;
                end
                if (tx_if.timeout) begin
                    check("timeout_latency", cyc - rel_cyc, TO_CYC);
                    check("timeout_oes", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
                end
            end
        end
        if (ps2_clk_oe && !prev_clk_oe) begin
            n_inhibit++;
            run = 0;
            seen_doe = 1'b0;
        end
        if (!ps2_clk_oe && prev_clk_oe) begin
            rel_cyc = cyc;
            last_win = run;
        end
        if (ps2_clk_oe) begin
            if (ps2_data_oe && !seen_doe) begin
                doe_off = run;
                seen_doe = 1'b1;
            end
            run++;
        end
        prev_clk_oe = ps2_clk_oe;
    end

    task automatic wait_ready(input int unsigned max_cyc);
        int unsigned w = 0;
        while (!tx_if.tx_ready && w < max_cyc) begin
            @(negedge clk);
            w++;
        end
        if (!tx_if.tx_ready) check("wait_ready_expired", 32'(tx_if.tx_ready), 32'd1);
    endtask

    task automatic drive_byte(input logic [7:0] d, input bit keep_valid);
        int unsigned w = 0;
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        while (!tx_if.tx_ready && w < 20000) begin
            @(negedge clk);
            w++;
        end
        if (!tx_if.tx_ready) check("accept_expired", 32'(tx_if.tx_ready), 32'd1);
        @(negedge clk);
        if (!keep_valid) tx_if.tx_valid = 1'b0;
    endtask

    // Device: start bit read once clk is released, then one bit per rising edge.
    task automatic device_frame(input bit ack_low, input int unsigned nbits, output logic [10:0] frame);
        int unsigned w = 0;
        logic [10:0] exp;
        frame = '0;
        while (!ps2_clk_oe && w < 500) begin @(negedge clk); w++; end
        if (!ps2_clk_oe) begin check("dev_wait_inhibit", 32'(ps2_clk_oe), 32'd1); return; end
        w = 0;
        while (ps2_clk_oe && w < 500) begin @(negedge clk); w++; end
        if (ps2_clk_oe) begin check("dev_wait_release", 32'(ps2_clk_oe), 32'd0); return; end
        repeat (20) @(negedge clk);
        frame[0] = ps2_data_in;
        for (int i = 1; i < int'(nbits); i++) begin
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            frame[i] = ps2_data_in;
            repeat (20) @(negedge clk);
        end
        if (nbits == 11) begin
            if (ack_low) dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (10) @(negedge clk);
            dev_data_low = 1'b0;
            if (exp_frames.size() == 0) begin
                check("unexpected_frame", 32'(frame), 32'd0);
            end else begin
                exp = exp_frames.pop_front();
                check("frame", 32'(frame), 32'(exp));
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL global_watchdog: got hang expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t        vecs[4];
        logic [10:0] fr;
        int unsigned inh0;
        int unsigned w;

        // {data, device acks low, frame {stop,parity,data,start}, ack_err}
        vecs[0] = '{8'hED, 1'b1, 11'h7DA, 1'b0};
        vecs[1] = '{8'hFF, 1'b0, 11'h7FE, 1'b1};
        vecs[2] = '{8'h55, 1'b1, 11'h6AA, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 11'h500, 1'b0};

        rst = 1'b0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        dev_clk_low    = 1'b0;
        dev_data_low   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_done", 32'(tx_if.done), 32'd0);
        check("rst_ack_err", 32'(tx_if.ack_err), 32'd0);
        check("rst_timeout", 32'(tx_if.timeout), 32'd0);
        check("rst_tx_ready", 32'(tx_if.tx_ready), 32'd1);
        check("rst_busy", 32'(tx_if.busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            exp_frames.push_back(vecs[i].frame);
            exp_evt.push_back({EV_DONE, vecs[i].ack_err});
            fork
                drive_byte(vecs[i].data, 1'b0);
                device_frame(vecs[i].ack_low, 11, fr);
            join
            wait_ready(200);
            repeat (3) @(negedge clk);
        end

        // Back-to-back: second request waits on busy and is taken the cycle ready returns.
        exp_frames.push_back(11'h40E);
        exp_frames.push_back(11'h600);
        exp_evt.push_back({EV_DONE, 1'b0});
        exp_evt.push_back({EV_DONE, 1'b0});
        fork
            begin
                drive_byte(8'h07, 1'b1);
                drive_byte(8'h00, 1'b0);
            end
            begin
                device_frame(1'b1, 11, fr);
                device_frame(1'b1, 11, fr);
            end
        join
        wait_ready(200);
        repeat (3) @(negedge clk);

        // tx_valid held with changing data: exactly one frame, OE window 25 with data at 20.
        inh0 = n_inhibit;
        exp_frames.push_back(11'h678);
        exp_evt.push_back({EV_DONE, 1'b0});
        fork
            begin
                drive_byte(8'h3C, 1'b1);
                tx_if.tx_data = 8'hA5;
                w = 0;
                while (!tx_if.done && w < 2000) begin @(negedge clk); w++; end
                check("hold_done_seen", 32'(tx_if.done), 32'd1);
                tx_if.tx_valid = 1'b0;
            end
            device_frame(1'b1, 11, fr);
        join
        repeat (100) @(negedge clk);
        check("hold_single_transfer", n_inhibit - inh0, 32'd1);
        check("clk_oe_window", last_win, 32'd25);
        check("data_oe_offset", doe_off, 32'd20);

        // Silent device: watchdog fires, monitor checks latency and released lines.
        exp_evt.push_back({EV_TO, 1'b0});
        drive_byte(8'h12, 1'b0);
        wait_ready(TO_CYC + 200);
        repeat (3) @(negedge clk);

        // Reset after data bit 4 (a 0, so data is still driven low).
        fork
            drive_byte(8'h4A, 1'b0);
            device_frame(1'b1, 6, fr);
        join
        check("partial_frame", 32'(fr[5:0]), 32'h14);
        check("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("midrst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("midrst_tx_ready", 32'(tx_if.tx_ready), 32'd1);
        check("midrst_no_evt", {30'd0, tx_if.done, tx_if.timeout}, 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        exp_frames.push_back(11'h5E8);
        exp_evt.push_back({EV_DONE, 1'b0});
        fork
            drive_byte(8'hF4, 1'b0);
            device_frame(1'b1, 11, fr);
        join
        wait_ready(200);
        repeat (5) @(negedge clk);

        check("events_outstanding", exp_evt.size(), 32'd0);
        check("frames_outstanding", exp_frames.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
